// File: rtl/data_mem_hs_pkg.sv
// Shared types and constants for the handshaked data memory.
// State encoding, lane geometry helpers and latency limits.
package data_mem_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int BE_W       = DATA_W_DEF / 8;
    localparam int OFS_W      = $clog2(BE_W);

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

    function automatic int ofs_w(input int dw);
        return (dw / 8 > 1) ? $clog2(dw / 8) : 0;
    endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response bundle between a memory client and data_mem_hs.
// The client drives master; the memory uses slave.
interface data_mem_hs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_mem_hs_mem_array_be.sv
// Synchronous word RAM with byte-lane write enables and one read port.
// Read data is held in an output register until the next read enable.
module mem_array_be #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = 7
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic                i_re,
    input  logic [IDX_W-1:0]    i_addr,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic [DATA_W-1:0]   o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/data_mem_hs.sv
// Handshaked data memory: one outstanding access, LATENCY cycles to response.
// Define DATA_MEM_HS_BOUNDS_CHECK_EN to fault out-of-range word indices.
module data_mem_hs
    import data_mem_hs_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    data_mem_hs_if.slave  bus
);
    localparam int L_BE_W  = DATA_W / 8;
    localparam int L_OFS_W = ofs_w(DATA_W);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("data_mem_hs: LATENCY out of range");
    end

    state_t             r_state;
    state_t             w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic               r_err;
    logic               w_err_nx;
    logic               r_rd_ok;
    logic               w_rd_ok_nx;

    logic               w_acc;
    logic               w_mis;
    logic               w_oob;
    logic               w_err;
    logic               w_wr;
    logic               w_rd;
    logic [IDX_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_q;

    assign w_mis = (bus.req_addr & ADDR_W'(L_BE_W - 1)) != '0;
    assign w_idx = bus.req_addr[L_OFS_W +: IDX_W];

`ifdef DATA_MEM_HS_BOUNDS_CHECK_EN
    logic [ADDR_W-L_OFS_W-1:0] w_widx;
    assign w_widx = bus.req_addr[ADDR_W-1:L_OFS_W];
    assign w_oob  = 32'(w_widx) >= 32'(DEPTH);
`else
    assign w_oob = 1'b0;
`endif

    assign w_acc = bus.req_valid & (r_state == IDLE);
    assign w_err = w_mis | w_oob;
    assign w_wr  = w_acc & bus.req_we & ~w_err;
    assign w_rd  = w_acc & ~bus.req_we & ~w_err;

    mem_array_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_wr),
        .i_re    (w_rd),
        .i_addr  (w_idx),
        .i_be    (bus.req_be),
        .i_wdata (bus.req_wdata),
        .o_rdata (w_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rd_ok <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_err   <= w_err_nx;
            r_rd_ok <= w_rd_ok_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_err_nx   = r_err;
        w_rd_ok_nx = r_rd_ok;
        unique case (r_state)
            IDLE: begin
                if (w_acc) begin
                    w_err_nx   = w_err;
                    w_rd_ok_nx = w_rd;
                    if (LATENCY == 1) begin
                        w_state_nx = RESP;
                        w_cnt_nx   = '0;
                    end else begin
                        w_state_nx = WAIT;
                        w_cnt_nx   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nx = RESP;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_nx = IDLE;
                    w_err_nx   = 1'b0;
                    w_rd_ok_nx = 1'b0;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // RAM output register holds the read word until the next read acceptance
    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_err   = (r_state == RESP) & r_err;
    assign bus.resp_rdata = ((r_state == RESP) && r_rd_ok) ? w_q : '0;

endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: LATENCY=1 and LATENCY=4 instances side by side.
// Vector table, reset corner cases and randomized ops against a word-array model.
module tb_data_mem_hs;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_hs_if #(.DATA_W(32), .ADDR_W(10)) b1 ();
    data_mem_hs_if #(.DATA_W(32), .ADDR_W(10)) b4 ();

    data_mem_hs #(
        .DATA_W(32), .DEPTH(128), .ADDR_W(10), .LATENCY(1)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    data_mem_hs #(
        .DATA_W(32), .DEPTH(128), .ADDR_W(10), .LATENCY(4)
    ) u4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    bit          sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_ready = 1'b0;

    assign b1.req_valid  = req_valid & ~sel;
    assign b4.req_valid  = req_valid & sel;
    assign b1.resp_ready = resp_ready & ~sel;
    assign b4.resp_ready = resp_ready & sel;
    assign b1.req_we     = req_we;
    assign b4.req_we     = req_we;
    assign b1.req_addr   = req_addr;
    assign b4.req_addr   = req_addr;
    assign b1.req_wdata  = req_wdata;
    assign b4.req_wdata  = req_wdata;
    assign b1.req_be     = req_be;
    assign b4.req_be     = req_be;

    logic        rdy, rv, rerr;
    logic [31:0] rdata;
    assign rdy   = sel ? b4.req_ready  : b1.req_ready;
    assign rv    = sel ? b4.resp_valid : b1.resp_valid;
    assign rerr  = sel ? b4.resp_err   : b1.resp_err;
    assign rdata = sel ? b4.resp_rdata : b1.resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_m [2][128];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic void model_access(
        input bit s, input bit we, input logic [9:0] a,
        input logic [31:0] wd, input logic [3:0] be,
        output logic [31:0] rd, output bit err);
        int w;
        w   = int'(a) / 4;
        err = (a % 4) != 0;
`ifdef DATA_MEM_HS_BOUNDS_CHECK_EN
        if (w >= 128) err = 1'b1;
`endif
        w  = w % 128;
        rd = '0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_m[s][w][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                rd = mem_m[s][w];
            end
        end
    endfunction

    task automatic do_access(
        input bit s, input bit we, input logic [9:0] a,
        input logic [31:0] wd, input logic [3:0] be, input int hold,
        input string nm,
        output logic [31:0] rd, output bit er, output int lat);
        int  n;
        bit  stable;
        bit  busy_bad;
        rd = '0;
        er = 1'b0;
        lat = 0;
        @(negedge clk);
        sel = s;
        #1;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_accept_ready"}, 32'(rdy), 32'd1);
        if (!rdy) return;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        @(posedge clk);
        stable   = 1'b1;
        busy_bad = 1'b0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = 10'(~a);
            req_wdata = ~wd;
            lat++;
            if (rdy) busy_bad = 1'b1;
        end while (!rv && lat < 40);
        if (!rv) begin
            chk({nm, "_resp_timeout"}, 32'(rv), 32'd1);
            return;
        end
        rd = rdata;
        er = rerr;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!rv || rdata !== rd || rerr !== er) stable = 1'b0;
            if (rdy) busy_bad = 1'b1;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk({nm, "_busy_req_ready"}, 32'(busy_bad), 32'd0);
        if (hold > 0) chk({nm, "_hold_stable"}, 32'(stable), 32'd1);
        chk({nm, "_post_valid"}, 32'(rv), 32'd0);
        chk({nm, "_post_rdata"}, rdata, 32'd0);
        chk({nm, "_post_ready"}, 32'(rdy), 32'd1);
    endtask

    task automatic run_op(input bit s, input bit we, input logic [9:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input int hold, input string nm);
        logic [31:0] erd, grd;
        bit          eer, ger;
        int          glat;
        model_access(s, we, a, wd, be, erd, eer);
        do_access(s, we, a, wd, be, hold, nm, grd, ger, glat);
        chk({nm, "_rdata"}, grd, erd);
        chk({nm, "_err"}, 32'(ger), 32'(eer));
        chk({nm, "_lat"}, 32'(glat), s ? 32'd4 : 32'd1);
    endtask

    typedef struct {
        bit          s;
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] grd;
        bit          ger;
        int          glat;
        bit          seen;
        bit          ready_ok;

        vecs[0]  = '{0, 1, 10'h010, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0, 1};
        vecs[1]  = '{0, 0, 10'h010, 32'h0,        4'h0, 0, 32'hDEADBEEF, 0, 1};
        vecs[2]  = '{0, 1, 10'h020, 32'h11223344, 4'hF, 0, 32'h0, 0, 1};
        vecs[3]  = '{0, 1, 10'h020, 32'hAABBCCDD, 4'h5, 1, 32'h0, 0, 1};
        vecs[4]  = '{0, 0, 10'h020, 32'h0,        4'h0, 0, 32'h11BB33DD, 0, 1};
        vecs[5]  = '{0, 1, 10'h013, 32'h0,        4'hF, 0, 32'h0, 1, 1};
        vecs[6]  = '{0, 0, 10'h010, 32'h0,        4'h0, 2, 32'hDEADBEEF, 0, 1};
        vecs[7]  = '{1, 1, 10'h010, 32'hCAFEF00D, 4'hF, 0, 32'h0, 0, 4};
        vecs[8]  = '{1, 0, 10'h010, 32'h0,        4'h0, 3, 32'hCAFEF00D, 0, 4};
        vecs[9]  = '{1, 0, 10'h012, 32'h0,        4'h0, 3, 32'h0, 1, 4};
        vecs[10] = '{0, 1, 10'h000, 32'h01020304, 4'hF, 0, 32'h0, 0, 1};
`ifdef DATA_MEM_HS_BOUNDS_CHECK_EN
        vecs[11] = '{0, 0, 10'h200, 32'h0,        4'h0, 0, 32'h0, 1, 1};
        vecs[12] = '{0, 1, 10'h200, 32'h55667788, 4'hF, 0, 32'h0, 1, 1};
        vecs[13] = '{0, 0, 10'h000, 32'h0,        4'h0, 0, 32'h01020304, 0, 1};
`else
        vecs[11] = '{0, 0, 10'h200, 32'h0,        4'h0, 0, 32'h01020304, 0, 1};
        vecs[12] = '{0, 1, 10'h200, 32'h55667788, 4'hF, 0, 32'h0, 0, 1};
        vecs[13] = '{0, 0, 10'h000, 32'h0,        4'h0, 0, 32'h55667788, 0, 1};
`endif
        vecs[14] = '{0, 1, 10'h010, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 0, 1};
        vecs[15] = '{0, 0, 10'h010, 32'h0,        4'h0, 0, 32'hDEADBEEF, 0, 1};

        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk($sformatf("reset%0d_req_ready", s), 32'(rdy), 32'd1);
            chk($sformatf("reset%0d_resp_valid", s), 32'(rv), 32'd0);
            chk($sformatf("reset%0d_resp_err", s), 32'(rerr), 32'd0);
            chk($sformatf("reset%0d_resp_rdata", s), rdata, 32'd0);
        end

        for (int i = 0; i < 16; i++) begin
            do_access(vecs[i].s, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].be, vecs[i].hold, $sformatf("vec%0d", i),
                      grd, ger, glat);
            chk($sformatf("vec%0d_rdata", i), grd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(ger), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_lat", i), 32'(glat), 32'(vecs[i].exp_lat));
        end

        // reset while the LATENCY=4 instance is waiting on a read
        @(negedge clk);
        sel = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h010; req_be = 4'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        ready_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (rv) seen = 1'b1;
            if (!rdy) ready_ok = 1'b0;
            @(negedge clk);
        end
        chk("rst_wait_resp_valid", 32'(seen), 32'd0);
        chk("rst_wait_req_ready", 32'(ready_ok), 32'd1);

        // a write committed at acceptance survives a reset during WAIT
        sel = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h030;
        req_wdata = 32'h12345678; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        do_access(1'b1, 1'b0, 10'h030, 32'h0, 4'h0, 0, "rst_write_kept",
                  grd, ger, glat);
        chk("rst_write_kept_rdata", grd, 32'h12345678);
        chk("rst_write_kept_err", 32'(ger), 32'd0);

        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 128; w++) begin
                run_op(s[0], 1'b1, 10'(w * 4), $urandom, 4'hF, 0,
                       $sformatf("init%0d_%0d", s, w));
            end
        end

        for (int i = 0; i < 150; i++) begin
            bit         rs, rwe;
            logic [9:0] ra;
            rs  = 1'($urandom_range(0, 1));
            rwe = 1'($urandom_range(0, 1));
            ra  = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            run_op(rs, rwe, ra, $urandom, 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
